bus_master_if: RTL and testbench

//  Per-master bus interface: the stage directly upstream of the 4-master bus arbiter.

---
 rtl/bus_master_if.sv | 141 ++++++++++++++
 tb/tb_bus_master_if.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_master_if.sv
// bus_master_if: per-master front end for the 4-master bus arbiter.
// Converts a local access strobe into the arbiter request/grant handshake, runs
// one shared-bus read or write, and returns data/ready (or a timeout error) to
// the local side. Master-side strobes are active-low, marked by a trailing '_'.
module bus_master_if #(
    parameter int ADDR_W  = 30,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_as_,
    input  logic              cpu_rw,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wr_data,
    output logic [DATA_W-1:0] cpu_rd_data,
    output logic              cpu_rdy_,
    output logic              cpu_err,
    output logic              cpu_busy,
    output logic              bus_req_,
    input  logic              bus_grnt_,
    output logic              bus_as_,
    output logic              bus_rw,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wr_data,
    input  logic [DATA_W-1:0] bus_rd_data,
    input  logic              bus_rdy_
);

    // Counter is at least one bit wide so TIMEOUT = 0 (timeout disabled) still elaborates.
    localparam int              CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit              TO_EN   = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        ACCESS = 2'd2,
        WAIT   = 2'd3
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] cpu_rd_data_q;
    logic              cpu_rdy_q;
    logic              cpu_err_q;
    logic              cpu_busy_q;
    logic              bus_req_q;
    logic              bus_as_q;
    logic              bus_rw_q;
    logic [ADDR_W-1:0] bus_addr_q;
    logic [DATA_W-1:0] bus_wr_data_q;

    logic done_ok_d;
    logic done_err_d;

    // Completion decode: slave ready wins over a timeout landing in the same cycle.
    always_comb begin
        done_ok_d  = 1'b0;
        done_err_d = 1'b0;
        if ((state_q == ACCESS) || (state_q == WAIT)) begin
            done_ok_d = ~bus_rdy_;
        end
        if (TO_EN && (state_q == WAIT) && bus_rdy_ && (cnt_q == TO_LAST)) begin
            done_err_d = 1'b1;
        end
    end

    // Transfer FSM with all outputs registered; completion pulses last one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            cpu_rd_data_q <= '0;
            cpu_rdy_q     <= 1'b1;
            cpu_err_q     <= 1'b0;
            cpu_busy_q    <= 1'b0;
            bus_req_q     <= 1'b1;
            bus_as_q      <= 1'b1;
            bus_rw_q      <= 1'b1;
            bus_addr_q    <= '0;
            bus_wr_data_q <= '0;
        end else begin
            cpu_rdy_q <= 1'b1;
            cpu_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!cpu_as_) begin
                        bus_addr_q    <= cpu_addr;
                        bus_rw_q      <= cpu_rw;
                        bus_wr_data_q <= cpu_wr_data;
                        bus_req_q     <= 1'b0;
                        cpu_busy_q    <= 1'b1;
                        cnt_q         <= '0;
                        state_q       <= REQ;
                    end
                end
                REQ: begin
                    if (!bus_grnt_) begin
                        bus_as_q <= 1'b0;
                        state_q  <= ACCESS;
                    end
                end
                ACCESS: begin
                    bus_as_q <= 1'b1;
                    state_q  <= WAIT;
                end
                WAIT: begin
                    cnt_q <= cnt_q + 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase

            if (done_ok_d || done_err_d) begin
                cpu_rdy_q  <= 1'b0;
                cpu_err_q  <= done_err_d;
                bus_req_q  <= 1'b1;
                cpu_busy_q <= 1'b0;
                state_q    <= IDLE;
                if (done_err_d) begin
                    cpu_rd_data_q <= '0;
                end else if (bus_rw_q) begin
                    cpu_rd_data_q <= bus_rd_data;
                end
            end
        end
    end

    assign cpu_rd_data = cpu_rd_data_q;
    assign cpu_rdy_    = cpu_rdy_q;
    assign cpu_err     = cpu_err_q;
    assign cpu_busy    = cpu_busy_q;
    assign bus_req_    = bus_req_q;
    assign bus_as_     = bus_as_q;
    assign bus_rw      = bus_rw_q;
    assign bus_addr    = bus_addr_q;
    assign bus_wr_data = bus_wr_data_q;

endmodule

// File: tb/tb_bus_master_if.sv
// Bench for bus_master_if: a default-TIMEOUT instance for handshake/data cases and
// a TIMEOUT=4 instance for the timeout case, each with a completion scoreboard.
module tb_bus_master_if;

    localparam int AW = 30;
    localparam int DW = 32;

    logic          clk;
    logic          reset;
    logic          cpu_as_;
    logic          cpu_rw;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wr_data;
    logic [DW-1:0] cpu_rd_data;
    logic          cpu_rdy_;
    logic          cpu_err;
    logic          cpu_busy;
    logic          bus_req_;
    logic          bus_grnt_;
    logic          bus_as_;
    logic          bus_rw;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wr_data;
    logic [DW-1:0] bus_rd_data;
    logic          bus_rdy_;

    logic          cpu_as_t;
    logic [DW-1:0] cpu_rd_data_t;
    logic          cpu_rdy_t;
    logic          cpu_err_t;
    logic          cpu_busy_t;
    logic          bus_req_t;
    logic          bus_grnt_t;
    logic          bus_as_t;
    logic          bus_rw_t;
    logic [AW-1:0] bus_addr_t;
    logic [DW-1:0] bus_wr_data_t;
    logic          bus_rdy_t;

    int nvec = 0;
    int nerr = 0;

    // Expected completions: {err, rd_data}
    logic [DW:0] sbq[$];
    logic [DW:0] sbq_t[$];

    bus_master_if #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset),
        .cpu_as_(cpu_as_), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr), .cpu_wr_data(cpu_wr_data),
        .cpu_rd_data(cpu_rd_data), .cpu_rdy_(cpu_rdy_), .cpu_err(cpu_err), .cpu_busy(cpu_busy),
        .bus_req_(bus_req_), .bus_grnt_(bus_grnt_), .bus_as_(bus_as_), .bus_rw(bus_rw),
        .bus_addr(bus_addr), .bus_wr_data(bus_wr_data), .bus_rd_data(bus_rd_data),
        .bus_rdy_(bus_rdy_)
    );

    bus_master_if #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(4)) dut_to (
        .clk(clk), .reset(reset),
        .cpu_as_(cpu_as_t), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr), .cpu_wr_data(cpu_wr_data),
        .cpu_rd_data(cpu_rd_data_t), .cpu_rdy_(cpu_rdy_t), .cpu_err(cpu_err_t),
        .cpu_busy(cpu_busy_t), .bus_req_(bus_req_t), .bus_grnt_(bus_grnt_t),
        .bus_as_(bus_as_t), .bus_rw(bus_rw_t), .bus_addr(bus_addr_t),
        .bus_wr_data(bus_wr_data_t), .bus_rd_data(bus_rd_data), .bus_rdy_(bus_rdy_t)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_req"},   bus_req_,    1);
        chk({tag, "_as"},    bus_as_,     1);
        chk({tag, "_rdy"},   cpu_rdy_,    1);
        chk({tag, "_err"},   cpu_err,     0);
        chk({tag, "_busy"},  cpu_busy,    0);
        chk({tag, "_rw"},    bus_rw,      1);
        chk({tag, "_addr"},  bus_addr,    0);
        chk({tag, "_wdata"}, bus_wr_data, 0);
        chk({tag, "_rdata"}, cpu_rd_data, 0);
    endtask

    // Scoreboard pop on every completion pulse of the main instance
    always @(negedge clk) begin
        if (cpu_rdy_ === 1'b0) begin
            if (sbq.size() == 0) begin
                chk("sb_unexpected_rdy", 1, 0);
            end else begin
                logic [DW:0] e;
                e = sbq.pop_front();
                chk("sb_rdata", cpu_rd_data, e[DW-1:0]);
                chk("sb_err", cpu_err, e[DW]);
            end
        end
    end

    // Scoreboard pop on every completion pulse of the timeout instance
    always @(negedge clk) begin
        if (cpu_rdy_t === 1'b0) begin
            if (sbq_t.size() == 0) begin
                chk("to_sb_unexpected_rdy", 1, 0);
            end else begin
                logic [DW:0] e;
                e = sbq_t.pop_front();
                chk("to_sb_rdata", cpu_rd_data_t, e[DW-1:0]);
                chk("to_sb_err", cpu_err_t, e[DW]);
            end
        end
    end

    initial begin
        reset = 1'b1; cpu_as_ = 1'b1; cpu_as_t = 1'b1; cpu_rw = 1'b1;
        cpu_addr = '0; cpu_wr_data = '0; bus_grnt_ = 1'b1; bus_grnt_t = 1'b0;
        bus_rdy_ = 1'b1; bus_rdy_t = 1'b1; bus_rd_data = '0;
        step(); step();
        check_reset_vals("reset");
        reset = 1'b0;
        step();

        // 1. Parked grant read, minimum latency
        bus_grnt_ = 1'b0;
        cpu_as_ = 1'b0; cpu_rw = 1'b1; cpu_addr = 30'h10;
        sbq.push_back({1'b0, 32'hDEADBEEF});
        step();                                     // T1
        cpu_as_ = 1'b1;
        chk("t1_req_T1", bus_req_, 0);
        chk("t1_busy_T1", cpu_busy, 1);
        chk("t1_as_T1", bus_as_, 1);
        chk("t1_addr", bus_addr, 30'h10);
        chk("t1_rw", bus_rw, 1);
        step();                                     // T2
        chk("t1_as_T2", bus_as_, 0);
        chk("t1_rdy_T2", cpu_rdy_, 1);
        bus_rdy_ = 1'b0; bus_rd_data = 32'hDEADBEEF;
        step();                                     // T3
        chk("t1_rdy_T3", cpu_rdy_, 0);
        chk("t1_req_T3", bus_req_, 1);
        chk("t1_as_T3", bus_as_, 1);
        bus_rdy_ = 1'b1; bus_rd_data = '0;
        step();                                     // T4
        chk("t1_rdy_T4", cpu_rdy_, 1);
        chk("t1_rdata_held", cpu_rd_data, 32'hDEADBEEF);

        // 2. Delayed grant write
        bus_grnt_ = 1'b1;
        cpu_as_ = 1'b0; cpu_rw = 1'b0; cpu_addr = 30'h2A; cpu_wr_data = 32'h12345678;
        sbq.push_back({1'b0, 32'hDEADBEEF});
        step();                                     // c1: bus_req_ falls
        cpu_as_ = 1'b1; cpu_addr = 30'h3FF; cpu_wr_data = 32'hFFFFFFFF;
        chk("t2_req", bus_req_, 0);
        for (int i = 0; i < 3; i++) begin
            step();                                 // c2..c4
            chk("t2_as_wait_grant", bus_as_, 1);
        end
        bus_grnt_ = 1'b0;                           // grant three cycles after req fell
        step();                                     // c5
        chk("t2_as_after_grant", bus_as_, 0);
        chk("t2_addr", bus_addr, 30'h2A);
        chk("t2_wdata", bus_wr_data, 32'h12345678);
        chk("t2_rw", bus_rw, 0);
        bus_grnt_ = 1'b1;
        bus_rdy_ = 1'b0; bus_rd_data = 32'h0BAD0BAD;
        step();                                     // c6
        chk("t2_rdy", cpu_rdy_, 0);
        chk("t2_rdata_unchanged", cpu_rd_data, 32'hDEADBEEF);
        bus_rdy_ = 1'b1; bus_rd_data = '0;
        step();

        // 3. Slave wait states (parked grant)
        bus_grnt_ = 1'b0;
        cpu_as_ = 1'b0; cpu_rw = 1'b1; cpu_addr = 30'h33;
        sbq.push_back({1'b0, 32'hCAFEF00D});
        step();                                     // c1
        cpu_as_ = 1'b1;
        step();                                     // c2 ACCESS
        chk("t3_as", bus_as_, 0);
        for (int i = 0; i < 5; i++) begin
            step();                                 // c3..c7
            chk("t3_req_held", bus_req_, 0);
            chk("t3_no_rdy", cpu_rdy_, 1);
        end
        bus_rdy_ = 1'b0; bus_rd_data = 32'hCAFEF00D;
        step();                                     // c8
        chk("t3_rdy", cpu_rdy_, 0);
        bus_rdy_ = 1'b1; bus_rd_data = '0;
        step();

        // 4. Timeout on the TIMEOUT=4 instance, then a normal access
        cpu_as_t = 1'b0; cpu_rw = 1'b1; cpu_addr = 30'h44;
        sbq_t.push_back({1'b1, 32'h0});
        step();                                     // c1
        cpu_as_t = 1'b1;
        chk("t4_req", bus_req_t, 0);
        step();                                     // c2
        chk("t4_as", bus_as_t, 0);
        for (int i = 0; i < 4; i++) begin
            step();                                 // c3..c6
            chk("t4_no_rdy", cpu_rdy_t, 1);
            chk("t4_req_held", bus_req_t, 0);
        end
        step();                                     // c7
        chk("t4_rdy", cpu_rdy_t, 0);
        chk("t4_err", cpu_err_t, 1);
        step();                                     // c8
        chk("t4_req_released", bus_req_t, 1);
        chk("t4_rdy_done", cpu_rdy_t, 1);
        cpu_as_t = 1'b0; cpu_rw = 1'b1; cpu_addr = 30'h45;
        sbq_t.push_back({1'b0, 32'h55AA55AA});
        step();
        cpu_as_t = 1'b1;
        step();                                     // ACCESS
        bus_rdy_t = 1'b0; bus_rd_data = 32'h55AA55AA;
        step();
        chk("t4_next_rdy", cpu_rdy_t, 0);
        chk("t4_next_err", cpu_err_t, 0);
        bus_rdy_t = 1'b1; bus_rd_data = '0;
        step();

        // 5. Ignored strobe while busy, then back-to-back
        cpu_as_ = 1'b0; cpu_rw = 1'b1; cpu_addr = 30'h50;
        sbq.push_back({1'b0, 32'h11111111});
        step();                                     // c1 REQ
        cpu_as_ = 1'b1;
        step();                                     // c2 ACCESS
        cpu_as_ = 1'b0; cpu_addr = 30'h5F;          // strobe while busy
        step();                                     // c3 WAIT
        chk("t5_as_ignored", bus_as_, 1);
        chk("t5_busy", cpu_busy, 1);
        chk("t5_addr_kept", bus_addr, 30'h50);
        cpu_as_ = 1'b0; cpu_addr = 30'h51; cpu_rw = 1'b0; cpu_wr_data = 32'hA5A5A5A5;
        bus_rdy_ = 1'b0; bus_rd_data = 32'h11111111;
        sbq.push_back({1'b0, 32'h11111111});
        step();                                     // c4 completion, IDLE
        chk("t5_rdy1", cpu_rdy_, 0);
        chk("t5_req_gap", bus_req_, 1);
        chk("t5_busy_gap", cpu_busy, 0);
        bus_rdy_ = 1'b1; bus_rd_data = '0;
        step();                                     // c5 second REQ
        cpu_as_ = 1'b1;
        chk("t5_req_again", bus_req_, 0);
        chk("t5_addr2", bus_addr, 30'h51);
        chk("t5_rw2", bus_rw, 0);
        chk("t5_wdata2", bus_wr_data, 32'hA5A5A5A5);
        step();                                     // c6 ACCESS
        chk("t5_as2", bus_as_, 0);
        bus_rdy_ = 1'b0;
        step();                                     // c7
        chk("t5_rdy2", cpu_rdy_, 0);
        bus_rdy_ = 1'b1;
        step();

        // 6. Asynchronous reset in WAIT, then a normal read
        cpu_as_ = 1'b0; cpu_rw = 1'b1; cpu_addr = 30'h60; cpu_wr_data = 32'h77777777;
        step();                                     // c1
        cpu_as_ = 1'b1;
        step();                                     // c2 ACCESS
        step();                                     // c3 WAIT
        chk("t6_busy_pre", cpu_busy, 1);
        reset = 1'b1;
        #1;
        check_reset_vals("t6_async");
        step();
        chk("t6_no_rdy", cpu_rdy_, 1);
        reset = 1'b0;
        step();
        cpu_as_ = 1'b0; cpu_rw = 1'b1; cpu_addr = 30'h61;
        sbq.push_back({1'b0, 32'h0BADF00D});
        step();
        cpu_as_ = 1'b1;
        step();                                     // ACCESS
        chk("t6_as", bus_as_, 0);
        bus_rdy_ = 1'b0; bus_rd_data = 32'h0BADF00D;
        step();
        chk("t6_rdy", cpu_rdy_, 0);
        bus_rdy_ = 1'b1; bus_rd_data = '0;
        step(); step(); step();

        chk("sb_drained", sbq.size(), 0);
        chk("to_sb_drained", sbq_t.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
